// File: rtl/shift_seq_ctrl.sv
// ---------------------------------------------------------------------------
// shift_seq_ctrl
//
// Sequencer for a WIDTH-bit loadable shift register bank.
// A start request in IDLE parallel-loads the bank and captures the shift
// direction and count (saturated to WIDTH). Then one single-bit shift is
// applied per clock until the count runs out, followed by a one-cycle done
// pulse. abort cancels an in-progress sequence without a done pulse.
//
// Configuration macro: SHIFT_SEQ_ROTATE_EN
//   defined   : rotate mode, the bit leaving the bank re-enters at the
//               vacated end and sin is unused.
//   undefined : sin is inserted at the vacated end (default).
//
// q, busy and done are registered. sout is combinational from q and the
// captured direction.
// ---------------------------------------------------------------------------
module shift_seq_ctrl #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             dir,
    input  logic [CW-1:0]    count,
    input  logic [WIDTH-1:0] load_val,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    localparam logic [CW-1:0] WIDTH_CW = CW'(WIDTH);
    localparam logic [CW-1:0] ZERO_CW  = {CW{1'b0}};
    localparam logic [CW-1:0] ONE_CW   = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [WIDTH-1:0]   q_r;
    logic [WIDTH-1:0]   q_s;
    logic               dir_r;
    logic               dir_s;
    logic [CW-1:0]      cnt_r;
    logic [CW-1:0]      cnt_s;
    logic               busy_r;
    logic               busy_s;
    logic               done_r;
    logic               done_s;

    logic [CW-1:0]      count_clamp_s;
    logic               fill_left_s;
    logic               fill_right_s;
    logic [WIDTH-1:0]   shifted_s;

`ifdef SHIFT_SEQ_ROTATE_EN
    // In rotate mode the serial input is deliberately left unconnected.
    logic               unused_sin_s;
    assign unused_sin_s = sin;
    assign fill_left_s  = q_r[WIDTH-1];
    assign fill_right_s = q_r[0];
`else
    assign fill_left_s  = sin;
    assign fill_right_s = sin;
`endif

    // Saturate the requested shift count to the bank width.
    always_comb begin
        if (count > WIDTH_CW) begin
            count_clamp_s = WIDTH_CW;
        end else begin
            count_clamp_s = count;
        end
    end

    // One-position shift of the bank in the captured direction.
    always_comb begin
        if (dir_r) begin
            shifted_s = {fill_right_s, q_r[WIDTH-1:1]};
        end else begin
            shifted_s = {q_r[WIDTH-2:0], fill_left_s};
        end
    end

    // Next-state, next-bank and next-output logic of the sequencer.
    always_comb begin
        state_s = state_r;
        q_s     = q_r;
        dir_s   = dir_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    q_s   = load_val;
                    dir_s = dir;
                    cnt_s = count_clamp_s;
                    if (count_clamp_s != ZERO_CW) begin
                        state_s = ST_SHIFT;
                    end else begin
                        state_s = ST_DONE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    // Cancel: bank holds, no completion pulse.
                    state_s = ST_IDLE;
                    cnt_s   = ZERO_CW;
                end else begin
                    q_s   = shifted_s;
                    cnt_s = cnt_r - ONE_CW;
                    if (cnt_r == ONE_CW) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_SHIFT;
                    end
                end
            end
            ST_DONE: begin
                // start is not queued here; always return to IDLE.
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = ZERO_CW;
            end
        endcase
        busy_s = (state_s == ST_SHIFT);
        done_s = (state_s == ST_DONE);
    end

    // State, bank and registered status outputs with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            q_r     <= {WIDTH{1'b0}};
            dir_r   <= 1'b0;
            cnt_r   <= ZERO_CW;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            q_r     <= q_s;
            dir_r   <= dir_s;
            cnt_r   <= cnt_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign q    = q_r;
    assign busy = busy_r;
    assign done = done_r;
    assign sout = dir_r ? q_r[0] : q_r[WIDTH-1];

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_shift_seq_ctrl
//
// Self-checking bench for shift_seq_ctrl (WIDTH=8). Directed scenarios
// followed by randomized transactions checked against an arithmetic model of
// the shift sequence. Honours SHIFT_SEQ_ROTATE_EN in its model.
// ---------------------------------------------------------------------------
module tb_shift_seq_ctrl;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic          dir;
    logic [CW-1:0] count;
    logic [W-1:0]  load_val;
    logic          sin;
    logic [W-1:0]  q;
    logic          sout;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    shift_seq_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .dir      (dir),
        .count    (count),
        .load_val (load_val),
        .sin      (sin),
        .q        (q),
        .sout     (sout),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // One active edge, then settle before sampling or driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: one single-bit shift computed arithmetically.
    function automatic logic [W-1:0] mdl_shift(input logic [W-1:0] v, input logic d, input logic s);
        int x;
        int fill;
        x = int'(v);
`ifdef SHIFT_SEQ_ROTATE_EN
        fill = d ? (x % 2) : (x / 128);
`else
        fill = int'(s);
`endif
        if (d == 1'b0) begin
            x = ((x * 2) % 256) + fill;
        end else begin
            x = (x / 2) + fill * 128;
        end
        return W'(x);
    endfunction

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; dir = 1'b0;
        count = 4'd0; load_val = 8'h00; sin = 1'b0;
        #3;
        checks++; if (q !== 8'h00)  begin errors++; $display("FAIL reset_q got %h exp 00", q); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        checks++; if (sout !== 1'b0) begin errors++; $display("FAIL reset_sout got %b exp 0", sout); end
        tick(); tick();
        rst = 1'b0;
        tick();
        checks++; if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL reset_idle got q=%h busy=%b done=%b exp 00/0/0", q, busy, done);
        end
    endtask

    task automatic test_left();
        int busy_n;
        int done_n;
        int done_at;
        logic [W-1:0] exp_q;
        exp_q = `ifdef SHIFT_SEQ_ROTATE_EN 8'h0C `else 8'h08 `endif;
        load_val = 8'h81; dir = 1'b0; count = 4'd3; sin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (q !== 8'h81) begin errors++; $display("FAIL left_load got %h exp 81", q); end
        busy_n = (busy === 1'b1) ? 1 : 0;
        done_n = (done === 1'b1) ? 1 : 0;
        done_at = -1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            if (busy === 1'b1) busy_n++;
            if (done === 1'b1) begin done_n++; done_at = e; end
            if (e == 3) begin
                checks++; if (q !== exp_q) begin errors++; $display("FAIL left_q got %h exp %h", q, exp_q); end
            end
        end
        checks++; if (busy_n != 3) begin errors++; $display("FAIL left_busy_cycles got %0d exp 3", busy_n); end
        checks++; if (done_n != 1 || done_at != 3) begin
            errors++; $display("FAIL left_done got %0d pulses at E%0d exp 1 at E3", done_n, done_at);
        end
    endtask

    task automatic test_right();
        logic [W-1:0] exp_q;
        int sout_bad;
        exp_q = `ifdef SHIFT_SEQ_ROTATE_EN 8'h00 `else 8'hF0 `endif;
        sout_bad = 0;
        load_val = 8'h00; dir = 1'b1; count = 4'd4; sin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 0; e < 4; e++) begin
            if (sout !== 1'b0) sout_bad++;
            tick();
        end
        if (sout !== 1'b0) sout_bad++;
        checks++; if (q !== exp_q) begin errors++; $display("FAIL right_q got %h exp %h", q, exp_q); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL right_done got %b exp 1", done); end
        checks++; if (sout_bad != 0) begin errors++; $display("FAIL right_sout got %0d nonzero samples exp 0", sout_bad); end
        sin = 1'b0;
        tick();
    endtask

    task automatic test_count_edges();
        int busy_n;
        logic [W-1:0] exp_q;
        // count = 0: straight to done after the start edge.
        load_val = 8'h5A; dir = 1'b0; count = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (q !== 8'h5A || busy !== 1'b0 || done !== 1'b1) begin
            errors++; $display("FAIL cnt0_after_e0 got q=%h busy=%b done=%b exp 5a/0/1", q, busy, done);
        end
        tick();
        checks++; if (busy !== 1'b0 || done !== 1'b0 || q !== 8'h5A) begin
            errors++; $display("FAIL cnt0_after_e1 got q=%h busy=%b done=%b exp 5a/0/0", q, busy, done);
        end
        // count = 15 saturates to 8.
        exp_q = `ifdef SHIFT_SEQ_ROTATE_EN 8'h00 `else 8'hFF `endif;
        load_val = 8'h00; dir = 1'b0; count = 4'd15; sin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        busy_n = 0;
        for (int e = 1; e <= 10; e++) begin
            if (busy === 1'b1) busy_n++;
            tick();
            if (e == 8) begin
                checks++; if (q !== exp_q || done !== 1'b1) begin
                    errors++; $display("FAIL sat_q got q=%h done=%b exp %h/1", q, done, exp_q);
                end
            end
        end
        checks++; if (busy_n != 8) begin errors++; $display("FAIL sat_busy_cycles got %0d exp 8", busy_n); end
        sin = 1'b0;
    endtask

    task automatic test_abort();
        int done_n;
        load_val = 8'h01; dir = 1'b0; count = 4'd6; sin = 1'b0; start = 1'b1;
        tick();
        // Start while busy with a different load value: must be ignored.
        load_val = 8'hFF; count = 4'd0;
        tick();
        start = 1'b0;
        checks++; if (q !== 8'h02) begin errors++; $display("FAIL abort_busy_start got %h exp 02", q); end
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++; if (q !== 8'h04 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL abort_e3 got q=%h busy=%b done=%b exp 04/0/0", q, busy, done);
        end
        done_n = 0;
        for (int e = 0; e < 3; e++) begin
            tick();
            if (done === 1'b1) done_n++;
        end
        checks++; if (done_n != 0 || q !== 8'h04) begin
            errors++; $display("FAIL abort_hold got q=%h done_pulses=%0d exp 04/0", q, done_n);
        end
        load_val = 8'h3C; count = 4'd1; start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (q !== 8'h3C || busy !== 1'b1) begin
            errors++; $display("FAIL abort_restart got q=%h busy=%b exp 3c/1", q, busy);
        end
        tick();
        checks++; if (q !== 8'h78 || done !== 1'b1) begin
            errors++; $display("FAIL abort_restart_done got q=%h done=%b exp 78/1", q, done);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        load_val = 8'hA5; dir = 1'b0; count = 4'd5; sin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        #2;
        rst = 1'b1;
        #1;
        checks++; if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL rst_mid got q=%h busy=%b done=%b exp 00/0/0", q, busy, done);
        end
        tick();
        rst = 1'b0;
        tick();
        checks++; if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL rst_mid_idle got q=%h busy=%b done=%b exp 00/0/0", q, busy, done);
        end
        load_val = 8'h33; count = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (q !== 8'h33 || done !== 1'b1) begin
            errors++; $display("FAIL rst_mid_restart got q=%h done=%b exp 33/1", q, done);
        end
        tick();
    endtask

    task automatic test_rotate();
        logic [W-1:0] exp_l;
        logic [W-1:0] exp_r;
        exp_l = `ifdef SHIFT_SEQ_ROTATE_EN 8'h03 `else 8'h02 `endif;
        exp_r = `ifdef SHIFT_SEQ_ROTATE_EN 8'hC0 `else 8'h40 `endif;
        sin = 1'b0;
        load_val = 8'h81; dir = 1'b0; count = 4'd1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checks++; if (q !== exp_l) begin errors++; $display("FAIL rot_left got %h exp %h", q, exp_l); end
        tick();
        load_val = 8'h81; dir = 1'b1; count = 4'd1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checks++; if (q !== exp_r) begin errors++; $display("FAIL rot_right got %h exp %h", q, exp_r); end
        tick();
    endtask

    // Random back-to-back transactions with junk start/abort where ignored.
    task automatic test_random(input int ntx);
        logic [W-1:0] ld;
        logic [W-1:0] exp_q;
        logic         d;
        logic         s;
        int           n;
        int           ab;
        int           c;
        for (int t = 0; t < ntx; t++) begin
            ld = W'($urandom);
            d  = 1'($urandom);
            c  = int'($urandom_range(0, 15));
            n  = (c > W) ? W : c;
            ab = (n > 0 && ($urandom % 4) == 0) ? int'($urandom_range(1, n)) : 0;
            exp_q = ld;
            load_val = ld; dir = d; count = CW'(c); abort = 1'b0; start = 1'b1;
            tick();
            checks++; if (q !== exp_q || busy !== (n > 0) || done !== (n == 0)) begin
                errors++; $display("FAIL rnd_start t=%0d got q=%h busy=%b done=%b exp %h/%b/%b",
                                   t, q, busy, done, exp_q, (n > 0), (n == 0));
            end
            for (int e = 1; e <= n; e++) begin
                s = 1'($urandom);
                sin = s; start = 1'($urandom); load_val = W'($urandom);
                dir = 1'($urandom); count = CW'($urandom);
                abort = (e == ab);
                tick();
                if (e == ab) begin
                    checks++; if (q !== exp_q || busy !== 1'b0 || done !== 1'b0) begin
                        errors++; $display("FAIL rnd_abort t=%0d got q=%h busy=%b done=%b exp %h/0/0",
                                           t, q, busy, done, exp_q);
                    end
                    break;
                end
                exp_q = mdl_shift(exp_q, d, s);
                checks++; if (q !== exp_q || busy !== (e < n) || done !== (e == n) ||
                              sout !== (d ? exp_q[0] : exp_q[W-1])) begin
                    errors++; $display("FAIL rnd_shift t=%0d e=%0d got q=%h busy=%b done=%b sout=%b exp %h/%b/%b/%b",
                                       t, e, q, busy, done, sout, exp_q, (e < n), (e == n),
                                       (d ? exp_q[0] : exp_q[W-1]));
                end
            end
            if (ab == 0) begin
                start = 1'($urandom); abort = 1'($urandom); load_val = W'($urandom);
                sin = 1'($urandom);
                tick();
                checks++; if (q !== exp_q || busy !== 1'b0 || done !== 1'b0) begin
                    errors++; $display("FAIL rnd_done_exit t=%0d got q=%h busy=%b done=%b exp %h/0/0",
                                       t, q, busy, done, exp_q);
                end
            end
            start = 1'b0;
            abort = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_left();
        test_right();
        test_count_edges();
        test_abort();
        test_reset_mid();
        test_rotate();
        test_random(200);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
